// File: rtl/mac_ctrl_pkg.sv
// Shared types and constants for the MAC sequencer family.
package mac_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        FETCH   = 3'd2,
        ISSUE   = 3'd3,
        WAIT    = 3'd4,
        CAPTURE = 3'd5,
        RESULT  = 3'd6
    } mac_seq_state_t;

    // Operand width of the signed MAC datapath.
    localparam int OPND_W        = 8;
    // Default accumulator / result width; must match the attached MAC.
    localparam int ACC_W_DEFAULT = 32;

endpackage

// File: rtl/mac_watchdog.sv
// Saturating per-operation watchdog. 'expired' is high during the cycle in
// which the number of consecutive enabled cycles reaches TIMEOUT, so the
// owner can leave its wait state on exactly the TIMEOUT-th cycle.
module mac_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_r;

    // Count enabled cycles since the last clear, holding at TIMEOUT.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    // The current enabled cycle is counted too, hence the TIMEOUT-1 compare.
    assign expired = en && (count_r >= CNT_LAST);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer for one signed MAC: takes a job length, streams
// operand pairs into the MAC one at a time, and returns the accumulator.
module mac_seq_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 16,
    parameter int ACC_W   = ACC_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [OPND_W-1:0] op_a,
    input  logic [OPND_W-1:0] op_b,
    output logic              mac_clear,
    output logic              mac_valid,
    output logic [OPND_W-1:0] mac_a,
    output logic [OPND_W-1:0] mac_b,
    input  logic              mac_done,
    input  logic [ACC_W-1:0]  mac_y,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_err
);

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    mac_seq_state_t   state_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] cnt_r;
    logic             wd_clr_s;
    logic             wd_en_s;
    logic             wd_expired_s;

    assign wd_clr_s = (state_r == ISSUE);
    assign wd_en_s  = (state_r == WAIT);

    mac_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (wd_clr_s),
        .en      (wd_en_s),
        .expired (wd_expired_s)
    );

    // Sequencer FSM; every output is registered and updated on the edge
    // that enters the state it belongs to, so outputs track the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            len_r     <= '0;
            cnt_r     <= '0;
            busy      <= 1'b0;
            op_ready  <= 1'b0;
            mac_clear <= 1'b1;
            mac_valid <= 1'b0;
            mac_a     <= '0;
            mac_b     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
        end else begin
            mac_clear <= 1'b0;
            mac_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        len_r     <= len;
                        busy      <= 1'b1;
                        mac_clear <= 1'b1;
                        state_r   <= CLEAR;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                CLEAR: begin
                    cnt_r <= '0;
                    if (len_r == '0) begin
                        state_r <= CAPTURE;
                    end else begin
                        op_ready <= 1'b1;
                        state_r  <= FETCH;
                    end
                end
                FETCH: begin
                    if (op_valid) begin
                        mac_a     <= op_a;
                        mac_b     <= op_b;
                        op_ready  <= 1'b0;
                        mac_valid <= 1'b1;
                        state_r   <= ISSUE;
                    end else begin
                        state_r <= FETCH;
                    end
                end
                ISSUE: begin
                    state_r <= WAIT;
                end
                WAIT: begin
                    // A completion on the last cycle before expiry still counts.
                    if (mac_done) begin
                        cnt_r <= cnt_r + LEN_ONE;
                        if ((cnt_r + LEN_ONE) == len_r) begin
                            state_r <= CAPTURE;
                        end else begin
                            op_ready <= 1'b1;
                            state_r  <= FETCH;
                        end
                    end else if (wd_expired_s) begin
                        res_err <= 1'b1;
                        state_r <= CAPTURE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                CAPTURE: begin
                    res_data  <= (len_r == '0) ? '0 : mac_y;
                    res_valid <= 1'b1;
                    state_r   <= RESULT;
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_err   <= 1'b0;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r <= RESULT;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    op_ready  <= 1'b0;
                    res_valid <= 1'b0;
                    res_err   <= 1'b0;
                    mac_clear <= 1'b1;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule
